// File: rtl/pe_array_seq.sv
// Operand sequencer for a ROWS x COLS systolic multiply array: streams K operand
// vectors from the A/B RAMs, skews them onto the array edges and sequences fill, drain and completion.

module pe_skew_lane #(
  parameter int DEPTH = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vld_i,
  input  logic [7:0] data_i,
  output logic       vld_o,
  output logic [7:0] data_o
);
  if (DEPTH == 0) begin : g_direct
    // Lane 0 forwards the RAM return directly but still holds its last word when idle.
    logic [7:0] hold_q;
    always_ff @(posedge clk) begin
      if (rst_n)      hold_q <= '0;
      else if (vld_i) hold_q <= data_i;
    end
    assign vld_o  = vld_i;
    assign data_o = vld_i ? data_i : hold_q;
  end else begin : g_skew
    logic [DEPTH-1:0] v_q;
    logic [7:0]       d_q [DEPTH];
    always_ff @(posedge clk) begin
      if (rst_n) begin
        v_q <= '0;
        for (int j = 0; j < DEPTH; j++) d_q[j] <= '0;
      end else begin
        v_q[0] <= vld_i;
        if (vld_i) d_q[0] <= data_i;
        for (int j = 1; j < DEPTH; j++) begin
          v_q[j] <= v_q[j-1];
          if (v_q[j-1]) d_q[j] <= d_q[j-1];
        end
      end
    end
    assign vld_o  = v_q[DEPTH-1];
    assign data_o = d_q[DEPTH-1];
  end
endmodule

module pe_array_seq #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int K_W         = 8,
  parameter int ADDR_W      = 8,
  parameter int DRAIN_EXTRA = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  input  logic [ROWS*8-1:0] a_rd_data,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  logic [COLS*8-1:0] b_rd_data,
  output logic [ROWS-1:0]   row_vld,
  output logic [ROWS*8-1:0] row_data,
  output logic [COLS-1:0]   col_vld,
  output logic [COLS*8-1:0] col_data,
  output logic              pe_en,
  input  logic              array_doing,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);
  localparam int DRAIN_N = ROWS + COLS + DRAIN_EXTRA;
  localparam int DRAIN_W = $clog2(DRAIN_N + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [K_W-1:0]      idx_q, idx_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [ADDR_W-1:0]   a_base_q, a_base_d;
  logic [ADDR_W-1:0]   b_base_q, b_base_d;
  logic                a_vld_q, b_vld_q;
  logic                fetch;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      k_q      <= '0;
      drain_q  <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      k_q      <= k_d;
      drain_q  <= drain_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      a_vld_q  <= a_rd_en;
      b_vld_q  <= b_rd_en;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    k_d      = k_q;
    drain_d  = drain_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            k_d      = k_len;
            a_base_d = a_base;
            b_base_d = b_base;
            idx_d    = '0;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (idx_q == k_q - K_W'(1)) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + K_W'(1);
        end
      end
      // Drain covers the skew depth of both edges plus the PE/result pipe.
      S_DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_N - 1)) state_d = S_WAIT;
        else                                  drain_d = drain_q + DRAIN_W'(1);
      end
      S_WAIT:  if (!array_doing) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign fetch     = (state_q == S_FETCH);
  assign a_rd_en   = fetch;
  assign b_rd_en   = fetch;
  assign a_rd_addr = fetch ? a_base_q + ADDR_W'(idx_q) : '0;
  assign b_rd_addr = fetch ? b_base_q + ADDR_W'(idx_q) : '0;
  assign pe_en     = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_WAIT);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    pe_skew_lane #(.DEPTH(r)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (a_vld_q),
      .data_i (a_rd_data[8*r +: 8]),
      .vld_o  (row_vld[r]),
      .data_o (row_data[8*r +: 8])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    pe_skew_lane #(.DEPTH(c)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (b_vld_q),
      .data_i (b_rd_data[8*c +: 8]),
      .vld_o  (col_vld[c]),
      .data_o (col_data[8*c +: 8])
    );
  end
endmodule

// File: tb/tb_pe_array_seq.sv
// Bench for pe_array_seq: RAM model, per-lane expected queues tagged with the
// cycle each word must appear on the array edge, and completion/occupancy checks per run.

module tb_pe_array_seq;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  k_len = '0;
  logic [7:0]  a_base = '0;
  logic [7:0]  b_base = '0;
  logic        a_rd_en, b_rd_en;
  logic [7:0]  a_rd_addr, b_rd_addr;
  logic [31:0] a_rd_data = '0;
  logic [31:0] b_rd_data = '0;
  logic [3:0]  row_vld, col_vld;
  logic [31:0] row_data, col_data;
  logic        pe_en, busy, done;
  logic        array_doing = 1'b0;
  logic [2:0]  dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          pe_cnt = 0;
  int          busy_cnt = 0;
  logic        mon_en = 1'b0;

  logic [39:0] row_q [ROWS][$];
  logic [39:0] col_q [COLS][$];
  logic [39:0] a_addr_q[$];
  logic [39:0] b_addr_q[$];
  logic [31:0] done_q[$];
  logic [39:0] mon_e;

  pe_array_seq #(.ROWS(ROWS), .COLS(COLS), .K_W(8), .ADDR_W(8), .DRAIN_EXTRA(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_len       (k_len),
    .a_base      (a_base),
    .b_base      (b_base),
    .a_rd_en     (a_rd_en),
    .a_rd_addr   (a_rd_addr),
    .a_rd_data   (a_rd_data),
    .b_rd_en     (b_rd_en),
    .b_rd_addr   (b_rd_addr),
    .b_rd_data   (b_rd_data),
    .row_vld     (row_vld),
    .row_data    (row_data),
    .col_vld     (col_vld),
    .col_data    (col_data),
    .pe_en       (pe_en),
    .array_doing (array_doing),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  function automatic logic [7:0] a_lane(input logic [7:0] addr, input int r);
    return addr + 8'(r * 37);
  endfunction

  function automatic logic [7:0] b_lane(input logic [7:0] addr, input int c);
    return ~addr ^ 8'(c * 53);
  endfunction

  function automatic logic [31:0] a_word(input logic [7:0] addr);
    logic [31:0] w;
    for (int r = 0; r < ROWS; r++) w[8*r +: 8] = a_lane(addr, r);
    return w;
  endfunction

  function automatic logic [31:0] b_word(input logic [7:0] addr);
    logic [31:0] w;
    for (int c = 0; c < COLS; c++) w[8*c +: 8] = b_lane(addr, c);
    return w;
  endfunction

  // Unread cycles return junk so any use of stale read data shows up.
  always @(posedge clk) begin
    a_rd_data <= a_rd_en ? a_word(a_rd_addr) : $urandom;
    b_rd_data <= b_rd_en ? b_word(b_rd_addr) : $urandom;
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (pe_en) pe_cnt++;
      if (busy)  busy_cnt++;
      for (int r = 0; r < ROWS; r++) begin
        if (row_vld[r]) begin
          if (row_q[r].size() == 0) chk("row_extra", 64'(cyc), 64'(0));
          else begin
            mon_e = row_q[r].pop_front();
            chk("row_lane", {24'd0, cyc, row_data[8*r +: 8]}, {24'd0, mon_e});
          end
        end else if (row_q[r].size() != 0 && row_q[r][0][39:8] < cyc) begin
          mon_e = row_q[r].pop_front();
          chk("row_miss", {24'd0, cyc, 8'h00}, {24'd0, mon_e});
        end
      end
      for (int c = 0; c < COLS; c++) begin
        if (col_vld[c]) begin
          if (col_q[c].size() == 0) chk("col_extra", 64'(cyc), 64'(0));
          else begin
            mon_e = col_q[c].pop_front();
            chk("col_lane", {24'd0, cyc, col_data[8*c +: 8]}, {24'd0, mon_e});
          end
        end else if (col_q[c].size() != 0 && col_q[c][0][39:8] < cyc) begin
          mon_e = col_q[c].pop_front();
          chk("col_miss", {24'd0, cyc, 8'h00}, {24'd0, mon_e});
        end
      end
      if (a_rd_en) begin
        if (a_addr_q.size() == 0) chk("a_rd_extra", 64'(cyc), 64'(0));
        else begin
          mon_e = a_addr_q.pop_front();
          chk("a_rd_addr", {24'd0, cyc, a_rd_addr}, {24'd0, mon_e});
        end
      end else if (a_addr_q.size() != 0 && a_addr_q[0][39:8] < cyc) begin
        mon_e = a_addr_q.pop_front();
        chk("a_rd_miss", {24'd0, cyc, 8'h00}, {24'd0, mon_e});
      end
      if (b_rd_en) begin
        if (b_addr_q.size() == 0) chk("b_rd_extra", 64'(cyc), 64'(0));
        else begin
          mon_e = b_addr_q.pop_front();
          chk("b_rd_addr", {24'd0, cyc, b_rd_addr}, {24'd0, mon_e});
        end
      end else if (b_addr_q.size() != 0 && b_addr_q[0][39:8] < cyc) begin
        mon_e = b_addr_q.pop_front();
        chk("b_rd_miss", {24'd0, cyc, 8'h00}, {24'd0, mon_e});
      end
      if (done) begin
        chk("done_busy", 64'(busy), 64'(0));
        if (done_q.size() == 0) chk("done_extra", 64'(cyc), 64'(0));
        else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end else if (done_q.size() != 0 && done_q[0] < cyc) begin
        chk("done_miss", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {a_rd_en, b_rd_en, row_vld, col_vld, pe_en, busy, done, dbg_state}, 64'(0));
    chk({tag, "_addr"}, {a_rd_addr, b_rd_addr}, 64'(0));
    chk({tag, "_row"}, row_data, 64'(0));
    chk({tag, "_col"}, col_data, 64'(0));
  endtask

  // One run started in the current cycle; array_doing is high over [dfrom,dto]
  // (relative cycles) and stray starts are pulsed at ign1/ign2.
  task automatic run(input int k, input logic [7:0] ab, input logic [7:0] bb,
                     input int dfrom, input int dto, input int ign1, input int ign2);
    int c0, done_rel, exp_en;
    c0       = cyc;
    done_rel = (k == 0) ? 1 : ((dto >= k + 11) ? dto + 2 : k + 12);
    exp_en   = (k == 0) ? 0 : done_rel - 1;
    for (int i = 0; i < k; i++) begin
      a_addr_q.push_back({32'(c0 + 1 + i), 8'(ab + i)});
      b_addr_q.push_back({32'(c0 + 1 + i), 8'(bb + i)});
      for (int r = 0; r < ROWS; r++) row_q[r].push_back({32'(c0 + 2 + i + r), a_lane(8'(ab + i), r)});
      for (int c = 0; c < COLS; c++) col_q[c].push_back({32'(c0 + 2 + i + c), b_lane(8'(bb + i), c)});
    end
    done_q.push_back(32'(c0 + done_rel));
    pe_cnt   = 0;
    busy_cnt = 0;
    for (int rel = 0; rel <= done_rel; rel++) begin
      if (rel == 0) begin
        start = 1'b1; k_len = 8'(k); a_base = ab; b_base = bb;
      end else if (rel == ign1 || rel == ign2) begin
        start = 1'b1; k_len = 8'($urandom_range(1, 255)); a_base = 8'($urandom); b_base = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      array_doing = (rel >= dfrom && rel <= dto);
      step();
    end
    start       = 1'b0;
    array_doing = 1'b0;
    chk("pe_cycles", 64'(pe_cnt), 64'(exp_en));
    chk("busy_cycles", 64'(busy_cnt), 64'(exp_en));
    chk("done_left", 64'(done_q.size()), 64'(0));
    chk("rd_left", 64'(a_addr_q.size() + b_addr_q.size()), 64'(0));
    if (k > 0) begin
      for (int r = 0; r < ROWS; r++) chk("row_hold", 64'(row_data[8*r +: 8]), 64'(a_lane(8'(ab + k - 1), r)));
      for (int c = 0; c < COLS; c++) chk("col_hold", 64'(col_data[8*c +: 8]), 64'(b_lane(8'(bb + k - 1), c)));
    end
  endtask

  task automatic reset_mid_run();
    mon_en = 1'b0;
    start  = 1'b1; k_len = 8'd6; a_base = 8'($urandom); b_base = 8'($urandom);
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_all_zero("midrst");
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
    end
    mon_en = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int dto;
    rst_n = 1'b1;
    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b0;
    step();
    mon_en = 1'b1;

    run(3, 8'h10, 8'h20, -1, -1, -1, -1);
    step();
    run(0, 8'h33, 8'h44, -1, -1, -1, -1);
    step();
    run(4, 8'hFE, 8'hFF, -1, -1, -1, -1);
    step();
    run(2, 8'h05, 8'h80, 10, 22, -1, -1);
    step();
    run(5, 8'h40, 8'hC0, -1, -1, 3, 17);
    run(4, 8'($urandom), 8'($urandom), -1, -1, -1, -1);
    step();
    reset_mid_run();
    run(3, 8'h10, 8'h20, -1, -1, -1, -1);

    for (int n = 0; n < 5; n++) begin
      k   = $urandom_range(1, 20);
      dto = ($urandom_range(0, 1) == 1) ? k + 11 + $urandom_range(0, 6) : -1;
      repeat ($urandom_range(0, 2)) step();
      run(k, 8'($urandom), 8'($urandom), k + 4, dto, 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
